peg_l2_mac_tx_framer: RTL and testbench
=======================================

Name: peg_l2_mac_tx_framer

Overview:
- Transmit-side L2 MAC framer, 8b pipeline, up to 1Gbps @ 125MHz.
- Accepts frames (DA onward) from the LLC and prepends 7-byte preamble + SFD.
- Pads short frames to minimum size, appends FCS from the external FCS calculator, then enforces inter-packet gap before emitting to the RS.
- Mirror of the RX parser; sits between the LLC TX path and the RS TX interface.

Parameters:
PKT_DATA_W, 8, data path width (only 8 supported)
MIN_FRM_BYTES, 60, minimum DA..payload bytes before FCS (64-byte frame incl. FCS)
IPG_W, 8, width of IPG config
DATA_CNTR_W, 16, frame byte counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
config_l2_mac_tx_en  in  1  accept new frames
config_l2_mac_tx_fcs_en  in  1  append FCS
config_l2_mac_tx_pad_en  in  1  pad short frames (see Optional Feature)
config_l2_mac_tx_ipg  in  IPG_W  idle cycles between frames
l2_mac_tx_fsm_state  out  4  current state encoding
tx_fcs_calc_init  out  1  pulse: clear CRC accumulator
tx_fcs_calc_en  out  1  byte on tx_fcs_calc_data is valid
tx_fcs_calc_data  out  PKT_DATA_W  byte to CRC
tx_fcs_value  in  32  final complemented FCS, valid the cycle after the last calc_en
llc_tx_valid / llc_tx_sop / llc_tx_eop  in  1 each  LLC stream qualifiers
llc_tx_data  in  PKT_DATA_W  LLC byte
llc_tx_error  in  1  byte-aligned error flag
llc_tx_ready  out  1  LLC backpressure
rs_tx_valid / rs_tx_sop / rs_tx_eop  out  1 each  RS stream qualifiers
rs_tx_data  out  PKT_DATA_W  RS byte
rs_tx_error  out  1  error propagated to RS
rs_tx_ready  in  1  RS backpressure

Behaviour:
- Reset: all outputs 0, FSM in IDLE_S, counters 0.
- Reset mid-frame aborts the frame; no eop is emitted.
- Output stage is a single register.
  - Advance condition: adv = ~rs_tx_valid | rs_tx_ready.
  - rs_tx_* remain stable while rs_tx_valid & ~rs_tx_ready.
- llc_tx_ready = (state==DATA_S) & adv. A byte transfers when llc_tx_valid & llc_tx_ready.
- States (4'd0..6):
  - IDLE_S: llc_tx_valid & llc_tx_sop & tx_en & adv -> PREAMBLE_S. tx_fcs_calc_init pulses on this transition. The first preamble byte is loaded the same cycle, so rs_tx_valid & rs_tx_sop appear 1 cycle after sop is seen. A frame with llc_tx_valid & ~llc_tx_sop in IDLE_S is held, not consumed. tx_en low mid-frame does not abort.
  - PREAMBLE_S: emit 0x55 on each adv; after 7 total -> SFD_S.
  - SFD_S: emit 0xD5, then -> DATA_S.
  - DATA_S: pass LLC bytes through; rs_tx_error = llc_tx_error for that byte; tx_fcs_calc_en asserted for the byte. llc_tx_sop inside DATA_S is ignored.
    - On llc eop: if byte count < MIN_FRM_BYTES and pad_en -> PAD_S; else if fcs_en -> FCS_S; else rs_tx_eop is set on that byte -> IPG_S.
  - PAD_S: emit 0x00 (CRC'd) until the count reaches MIN_FRM_BYTES, then -> FCS_S. If fcs_en=0, eop goes on the last pad byte -> IPG_S.
  - FCS_S: emit 4 bytes, tx_fcs_value[7:0] first through [31:24], not CRC'd. rs_tx_eop is set on byte 4 -> IPG_S. tx_fcs_value is sampled once, on FCS_S entry +0 cycles; the calculator latency (1 cycle) is guaranteed by the one-cycle FCS_S entry after the last calc_en.
  - IPG_S: count config_l2_mac_tx_ipg cycles after the eop byte is accepted by the RS (rs_tx_valid & rs_tx_ready & rs_tx_eop), then -> IDLE_S. A value of 0 returns to IDLE_S immediately after acceptance.
- Byte counter: reset on PREAMBLE_S entry; counts DATA_S/PAD_S bytes only; saturates at 2^DATA_CNTR_W-1.
- Errors: an error on any DATA byte does not truncate the frame; the FCS is still appended.
- Simultaneous eop & error: error is flagged on the eop byte, and eop handling is unchanged.

Optional Feature:
- Macro: PEG_L2_MAC_TX_PAD_EN.
- Defined: PAD_S is present and config_l2_mac_tx_pad_en is honoured.
- Undefined: PAD_S is removed; the config input is ignored; short frames go straight to FCS_S/IPG_S unpadded. State encoding is unchanged.

Decomposition:
- Shared L2 params include holds the common constants:
  - PREAMBLE_VALUE, SFD_VALUE
  - MIN frame size
  - state encodings
  - FCS byte count (4)
- Sub-module peg_l2_mac_tx_ipg_cntr: loadable down-counter with a done flag.

Test Plan:
- 64B frame (60 data), fcs_en=1, ipg=12, rs_tx_ready=1 -> rs shows 7x0x55, 0xD5, 60 data bytes, 4 FCS bytes with eop on the last; sop on the first 0x55; next sop no earlier than 12 cycles after eop.
- 20-byte frame, pad_en=1 -> 40 bytes of 0x00 after the data; the FCS covers the pad; total 72 RS bytes.
- rs_tx_ready toggled 1010... during DATA_S -> no byte lost or duplicated; llc_tx_ready low whenever rs stalls; output stable during the stall.
- fcs_en=0, 100-byte frame -> eop on data byte 100; tx_fcs_calc_en still pulses 100 times.
- llc_tx_error on byte 30 -> rs_tx_error high on exactly that RS byte; the frame completes with FCS.
- rst_n asserted during DATA_S -> all outputs 0 next edge; a new sop after release gives a clean frame starting with 0x55.

Source files
------------

// File: rtl/peg_l2_mac_tx_framer_pkg.sv
// Shared L2 MAC TX constants: line-coding bytes, frame sizing and FSM state encodings.
package peg_l2_mac_tx_framer_pkg;

   localparam logic [7:0] PREAMBLE_VALUE    = 8'h55;
   localparam logic [7:0] SFD_VALUE         = 8'hD5;
   localparam int         PREAMBLE_BYTES    = 7;
   localparam int         MIN_FRM_BYTES_DEF = 60;
   localparam int         FCS_BYTES         = 4;

   localparam logic [3:0] IDLE_S     = 4'd0;
   localparam logic [3:0] PREAMBLE_S = 4'd1;
   localparam logic [3:0] SFD_S      = 4'd2;
   localparam logic [3:0] DATA_S     = 4'd3;
   localparam logic [3:0] PAD_S      = 4'd4;
   localparam logic [3:0] FCS_S      = 4'd5;
   localparam logic [3:0] IPG_S      = 4'd6;

endpackage

// File: rtl/peg_l2_mac_tx_framer_ipg_cntr.sv
// Loadable down-counter for the inter-packet gap; done is high once the count has drained.
module peg_l2_mac_tx_ipg_cntr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign done = (cnt == '0) & ~load;

endmodule

// File: rtl/peg_l2_mac_tx_framer.sv
// L2 MAC TX framer: preamble/SFD insertion, optional padding, FCS append and IPG enforcement.
// Padding (PAD_S) exists only when PEG_L2_MAC_TX_PAD_EN is defined.
module peg_l2_mac_tx_framer
   import peg_l2_mac_tx_framer_pkg::*;
#(
   parameter int PKT_DATA_W    = 8,
   parameter int MIN_FRM_BYTES = MIN_FRM_BYTES_DEF,
   parameter int IPG_W         = 8,
   parameter int DATA_CNTR_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  config_l2_mac_tx_en,
   input  logic                  config_l2_mac_tx_fcs_en,
   input  logic                  config_l2_mac_tx_pad_en,
   input  logic [IPG_W-1:0]      config_l2_mac_tx_ipg,
   output logic [3:0]            l2_mac_tx_fsm_state,
   output logic                  tx_fcs_calc_init,
   output logic                  tx_fcs_calc_en,
   output logic [PKT_DATA_W-1:0] tx_fcs_calc_data,
   input  logic [31:0]           tx_fcs_value,
   input  logic                  llc_tx_valid,
   input  logic                  llc_tx_sop,
   input  logic                  llc_tx_eop,
   input  logic [PKT_DATA_W-1:0] llc_tx_data,
   input  logic                  llc_tx_error,
   output logic                  llc_tx_ready,
   output logic                  rs_tx_valid,
   output logic                  rs_tx_sop,
   output logic                  rs_tx_eop,
   output logic [PKT_DATA_W-1:0] rs_tx_data,
   output logic                  rs_tx_error,
   input  logic                  rs_tx_ready
);

   function automatic logic [DATA_CNTR_W-1:0] sat_inc(input logic [DATA_CNTR_W-1:0] c);
      return (c == '1) ? c : c + DATA_CNTR_W'(1);
   endfunction

   logic [3:0]             state;
   logic [2:0]             pre_cnt;
   logic [1:0]             fcs_cnt;
   logic                   fcs_held;
   logic [31:0]            fcs_lat;
   logic [31:0]            fcs_word;
   logic [DATA_CNTR_W-1:0] byte_cnt;
   logic [DATA_CNTR_W-1:0] byte_cnt_inc;
   logic                   adv;
   logic                   start;
   logic                   llc_xfer;
   logic                   short_frm;
   logic                   pad_req;
   logic                   pad_byte;
   logic                   ipg_load;
   logic                   ipg_done;

   assign adv          = ~rs_tx_valid | rs_tx_ready;
   assign llc_tx_ready = (state == DATA_S) & adv;
   assign llc_xfer     = llc_tx_valid & llc_tx_ready;
   assign start        = (state == IDLE_S) & llc_tx_valid & llc_tx_sop & config_l2_mac_tx_en & adv;
   assign byte_cnt_inc = sat_inc(byte_cnt);
   assign short_frm    = byte_cnt_inc < DATA_CNTR_W'(MIN_FRM_BYTES);

`ifdef PEG_L2_MAC_TX_PAD_EN
   assign pad_req  = config_l2_mac_tx_pad_en & short_frm;
   assign pad_byte = (state == PAD_S) & adv;
`else
   logic unused_pad;
   assign unused_pad = config_l2_mac_tx_pad_en & short_frm;
   assign pad_req    = 1'b0;
   assign pad_byte   = 1'b0;
`endif

   assign tx_fcs_calc_en      = llc_xfer | pad_byte;
   assign tx_fcs_calc_data    = (state == DATA_S) ? llc_tx_data : '0;
   assign l2_mac_tx_fsm_state = state;

   // The calculator output is only guaranteed on the first FCS_S cycle, so hold it for bytes 2..4.
   assign fcs_word = fcs_held ? fcs_lat : tx_fcs_value;

   always_ff @(posedge clk) begin
      if ((state == FCS_S) && !fcs_held)
         fcs_lat <= tx_fcs_value;
   end

   assign ipg_load = (state == IPG_S) & rs_tx_valid & rs_tx_ready & rs_tx_eop
                   & (config_l2_mac_tx_ipg != '0);

   peg_l2_mac_tx_ipg_cntr #(.W(IPG_W)) u_ipg_cntr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ipg_load),
      .load_val (config_l2_mac_tx_ipg - IPG_W'(1)),
      .done     (ipg_done)
   );

   // FSM and single output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE_S;
         pre_cnt          <= '0;
         fcs_cnt          <= '0;
         fcs_held         <= 1'b0;
         byte_cnt         <= '0;
         tx_fcs_calc_init <= 1'b0;
         rs_tx_valid      <= 1'b0;
         rs_tx_sop        <= 1'b0;
         rs_tx_eop        <= 1'b0;
         rs_tx_error      <= 1'b0;
         rs_tx_data       <= '0;
      end else begin
         tx_fcs_calc_init <= 1'b0;
         fcs_held         <= (state == FCS_S);
         if (adv) begin
            rs_tx_valid <= 1'b0;
            rs_tx_sop   <= 1'b0;
            rs_tx_eop   <= 1'b0;
            rs_tx_error <= 1'b0;
         end
         case (state)
            IDLE_S: if (start) begin
               state            <= PREAMBLE_S;
               tx_fcs_calc_init <= 1'b1;
               pre_cnt          <= 3'd1;
               fcs_cnt          <= '0;
               byte_cnt         <= '0;
               rs_tx_valid      <= 1'b1;
               rs_tx_sop        <= 1'b1;
               rs_tx_data       <= PREAMBLE_VALUE;
            end
            PREAMBLE_S: if (adv) begin
               rs_tx_valid <= 1'b1;
               rs_tx_data  <= PREAMBLE_VALUE;
               pre_cnt     <= pre_cnt + 3'd1;
               if (pre_cnt == 3'(PREAMBLE_BYTES - 1))
                  state <= SFD_S;
            end
            SFD_S: if (adv) begin
               rs_tx_valid <= 1'b1;
               rs_tx_data  <= SFD_VALUE;
               state       <= DATA_S;
            end
            DATA_S: if (llc_xfer) begin
               rs_tx_valid <= 1'b1;
               rs_tx_data  <= llc_tx_data;
               rs_tx_error <= llc_tx_error;
               byte_cnt    <= byte_cnt_inc;
               if (llc_tx_eop) begin
                  if (pad_req)
                     state <= PAD_S;
                  else if (config_l2_mac_tx_fcs_en)
                     state <= FCS_S;
                  else begin
                     rs_tx_eop <= 1'b1;
                     state     <= IPG_S;
                  end
               end
            end
`ifdef PEG_L2_MAC_TX_PAD_EN
            PAD_S: if (adv) begin
               rs_tx_valid <= 1'b1;
               rs_tx_data  <= '0;
               byte_cnt    <= byte_cnt_inc;
               if (!short_frm) begin
                  if (config_l2_mac_tx_fcs_en)
                     state <= FCS_S;
                  else begin
                     rs_tx_eop <= 1'b1;
                     state     <= IPG_S;
                  end
               end
            end
`endif
            FCS_S: if (adv) begin
               rs_tx_valid <= 1'b1;
               rs_tx_data  <= fcs_word[{fcs_cnt, 3'b000} +: 8];
               fcs_cnt     <= fcs_cnt + 2'd1;
               if (fcs_cnt == 2'(FCS_BYTES - 1)) begin
                  rs_tx_eop <= 1'b1;
                  state     <= IPG_S;
               end
            end
            IPG_S: begin
               // rs_tx_valid here is the eop byte still waiting for the RS
               if (rs_tx_valid) begin
                  if (rs_tx_ready && (config_l2_mac_tx_ipg == '0))
                     state <= IDLE_S;
               end else if (ipg_done)
                  state <= IDLE_S;
            end
            default: state <= IDLE_S;
         endcase
      end
   end

endmodule

// File: tb/tb_peg_l2_mac_tx_framer.sv
// Scoreboard bench for peg_l2_mac_tx_framer; emulates the external CRC-32 calculator.
module tb_peg_l2_mac_tx_framer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        config_l2_mac_tx_en = 1'b1;
   logic        config_l2_mac_tx_fcs_en = 1'b1;
   logic        config_l2_mac_tx_pad_en = 1'b1;
   logic [7:0]  config_l2_mac_tx_ipg = 8'd12;
   logic [3:0]  l2_mac_tx_fsm_state;
   logic        tx_fcs_calc_init;
   logic        tx_fcs_calc_en;
   logic [7:0]  tx_fcs_calc_data;
   logic [31:0] tx_fcs_value;
   logic        llc_tx_valid = 1'b0;
   logic        llc_tx_sop = 1'b0;
   logic        llc_tx_eop = 1'b0;
   logic [7:0]  llc_tx_data = 8'h00;
   logic        llc_tx_error = 1'b0;
   logic        llc_tx_ready;
   logic        rs_tx_valid;
   logic        rs_tx_sop;
   logic        rs_tx_eop;
   logic [7:0]  rs_tx_data;
   logic        rs_tx_error;
   logic        rs_tx_ready = 1'b1;

   always #4 clk = ~clk;

   peg_l2_mac_tx_framer dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .config_l2_mac_tx_en     (config_l2_mac_tx_en),
      .config_l2_mac_tx_fcs_en (config_l2_mac_tx_fcs_en),
      .config_l2_mac_tx_pad_en (config_l2_mac_tx_pad_en),
      .config_l2_mac_tx_ipg    (config_l2_mac_tx_ipg),
      .l2_mac_tx_fsm_state     (l2_mac_tx_fsm_state),
      .tx_fcs_calc_init        (tx_fcs_calc_init),
      .tx_fcs_calc_en          (tx_fcs_calc_en),
      .tx_fcs_calc_data        (tx_fcs_calc_data),
      .tx_fcs_value            (tx_fcs_value),
      .llc_tx_valid            (llc_tx_valid),
      .llc_tx_sop              (llc_tx_sop),
      .llc_tx_eop              (llc_tx_eop),
      .llc_tx_data             (llc_tx_data),
      .llc_tx_error            (llc_tx_error),
      .llc_tx_ready            (llc_tx_ready),
      .rs_tx_valid             (rs_tx_valid),
      .rs_tx_sop               (rs_tx_sop),
      .rs_tx_eop               (rs_tx_eop),
      .rs_tx_data              (rs_tx_data),
      .rs_tx_error             (rs_tx_error),
      .rs_tx_ready             (rs_tx_ready)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic       err;
   } beat_t;

   beat_t       exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          last_eop = -1;
   int          calc_cnt = 0;
   int          init_cnt = 0;
   int          ipg_cfg = 12;
   bit          ready_toggle = 1'b0;
   logic [31:0] crc_acc = 32'hFFFF_FFFF;

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [7:0] pat(input int i, input int seed);
      return 8'((i * 7 + seed) & 255);
   endfunction

   // External FCS calculator model: result is valid the cycle after the last calc_en
   always @(posedge clk) begin
      if (tx_fcs_calc_init)
         crc_acc <= 32'hFFFF_FFFF;
      else if (tx_fcs_calc_en)
         crc_acc <= crc_upd(crc_acc, tx_fcs_calc_data);
   end
   assign tx_fcs_value = ~crc_acc;

   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      rs_tx_ready = ready_toggle ? ~rs_tx_ready : 1'b1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_fcs_calc_en)   calc_cnt++;
         if (tx_fcs_calc_init) init_cnt++;
      end
   end

   // Monitor: pops the scoreboard on every accepted RS byte
   beat_t prev_beat;
   bit    prev_stall = 1'b0;
   always @(negedge clk) begin
      beat_t a;
      beat_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         a.data = rs_tx_data;
         a.sop  = rs_tx_sop;
         a.eop  = rs_tx_eop;
         a.err  = rs_tx_error;
         if (prev_stall) begin
            checks++;
            if (!rs_tx_valid || (a !== prev_beat)) begin
               failures++;
               $display("FAIL stall_hold: got v=%0b %h required v=1 %h", rs_tx_valid, a, prev_beat);
            end
         end
         if (rs_tx_valid && !rs_tx_ready) begin
            checks++;
            if (llc_tx_ready !== 1'b0) begin
               failures++;
               $display("FAIL llc_ready_stall: got %0b required 0", llc_tx_ready);
            end
         end
         if (rs_tx_valid && rs_tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat: got data=%02h sop=%0b eop=%0b err=%0b required none",
                        a.data, a.sop, a.eop, a.err);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  failures++;
                  $display("FAIL beat: got data=%02h sop=%0b eop=%0b err=%0b required data=%02h sop=%0b eop=%0b err=%0b",
                           a.data, a.sop, a.eop, a.err, e.data, e.sop, e.eop, e.err);
               end
            end
            if (rs_tx_sop && last_eop >= 0) begin
               checks++;
               if (cyc - last_eop < ipg_cfg) begin
                  failures++;
                  $display("FAIL ipg_gap: got %0d cycles required >= %0d", cyc - last_eop, ipg_cfg);
               end
            end
            if (rs_tx_eop) last_eop = cyc;
         end
         prev_stall = rs_tx_valid && !rs_tx_ready;
         prev_beat  = a;
      end
   end

   task automatic push_frame(input int len, input int err_idx, input bit pad, input bit fcs,
                             input int seed, output int n_calc);
      beat_t       f[$];
      beat_t       b;
      logic [31:0] c;
      logic [31:0] fv;
      int          npad;
      c    = 32'hFFFF_FFFF;
      npad = 0;
`ifdef PEG_L2_MAC_TX_PAD_EN
      if (pad && len < 60) npad = 60 - len;
`else
      if (pad) npad = 0;
`endif
      for (int i = 0; i < 8; i++) begin
         b.data = (i < 7) ? 8'h55 : 8'hD5;
         b.sop  = (i == 0);
         b.eop  = 1'b0;
         b.err  = 1'b0;
         f.push_back(b);
      end
      for (int i = 0; i < len; i++) begin
         b.data = pat(i, seed);
         b.sop  = 1'b0;
         b.err  = (i == err_idx);
         c      = crc_upd(c, b.data);
         f.push_back(b);
      end
      for (int i = 0; i < npad; i++) begin
         b.data = 8'h00;
         b.err  = 1'b0;
         c      = crc_upd(c, 8'h00);
         f.push_back(b);
      end
      if (fcs) begin
         fv = ~c;
         for (int k = 0; k < 4; k++) begin
            b.data = fv[8*k +: 8];
            b.err  = 1'b0;
            f.push_back(b);
         end
      end
      f[f.size()-1].eop = 1'b1;
      foreach (f[i]) exp_q.push_back(f[i]);
      n_calc = len + npad;
   endtask

   task automatic run_frame(input int len, input int err_idx, input bit pad, input bit fcs,
                            input bit toggle, input int seed, input int abort_after);
      int n_calc;
      int wait_cnt;
      bit ok;
      config_l2_mac_tx_pad_en = pad;
      config_l2_mac_tx_fcs_en = fcs;
      calc_cnt     = 0;
      init_cnt     = 0;
      push_frame(len, err_idx, pad, fcs, seed, n_calc);
      ready_toggle = toggle;
      ok = 1'b1;
      for (int i = 0; i < len && ok; i++) begin
         llc_tx_valid = 1'b1;
         llc_tx_sop   = (i == 0);
         llc_tx_eop   = (i == len - 1);
         llc_tx_data  = pat(i, seed);
         llc_tx_error = (i == err_idx);
         wait_cnt = 0;
         while (1) begin
            @(negedge clk);
            if (llc_tx_ready) break;
            wait_cnt++;
            if (wait_cnt > 500) begin
               checks++;
               failures++;
               $display("FAIL llc_handshake_timeout: got no ready required ready for byte %0d", i);
               ok = 1'b0;
               break;
            end
         end
         if (ok) begin
            @(posedge clk);
            #1;
         end
         if (ok && abort_after == i + 1) begin
            rst_n = 1'b0;
            #1;
            check("reset_abort_outputs",
                  {rs_tx_valid, rs_tx_sop, rs_tx_eop, rs_tx_error, rs_tx_data, llc_tx_ready,
                   l2_mac_tx_fsm_state, tx_fcs_calc_en, tx_fcs_calc_init}, 64'h0);
            exp_q.delete();
            llc_tx_valid = 1'b0;
            llc_tx_sop   = 1'b0;
            llc_tx_eop   = 1'b0;
            llc_tx_error = 1'b0;
            last_eop     = -1;
            ready_toggle = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
      end
      llc_tx_valid = 1'b0;
      llc_tx_sop   = 1'b0;
      llc_tx_eop   = 1'b0;
      llc_tx_error = 1'b0;
      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 2000) begin
         @(posedge clk);
         wait_cnt++;
      end
      #1;
      ready_toggle = 1'b0;
      check("frame_drained", exp_q.size(), 0);
      check("calc_en_count", calc_cnt, n_calc);
      check("calc_init_count", init_cnt, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_rs_valid", rs_tx_valid, 0);
      check("reset_rs_flags", {rs_tx_sop, rs_tx_eop, rs_tx_error}, 0);
      check("reset_rs_data", rs_tx_data, 0);
      check("reset_state", l2_mac_tx_fsm_state, 0);
      check("reset_llc_ready", llc_tx_ready, 0);
      check("reset_fcs_ctrl", {tx_fcs_calc_init, tx_fcs_calc_en}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Disabled framer must hold a pending sop without starting
      config_l2_mac_tx_en = 1'b0;
      llc_tx_valid = 1'b1;
      llc_tx_sop   = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("tx_en_low_state", l2_mac_tx_fsm_state, 0);
      check("tx_en_low_valid", rs_tx_valid, 0);
      llc_tx_valid = 1'b0;
      llc_tx_sop   = 1'b0;
      config_l2_mac_tx_en = 1'b1;

      run_frame(60,  -1, 1'b1, 1'b1, 1'b0,  3, 0);
      run_frame(20,  -1, 1'b1, 1'b1, 1'b0,  5, 0);
      run_frame(59,  -1, 1'b1, 1'b1, 1'b0,  9, 0);
      run_frame(40,  -1, 1'b1, 1'b1, 1'b1, 11, 0);
      run_frame(100, -1, 1'b0, 1'b0, 1'b0, 13, 0);
      run_frame(20,  -1, 1'b0, 1'b0, 1'b0, 17, 0);
      run_frame(64,  29, 1'b1, 1'b1, 1'b0, 19, 0);
      run_frame(70,  -1, 1'b1, 1'b1, 1'b0, 23, 10);
      run_frame(60,  -1, 1'b1, 1'b1, 1'b0, 29, 0);
      repeat (20) @(posedge clk);
      #1;
      check("final_idle", l2_mac_tx_fsm_state, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
